// File: rtl/heq_pkg.sv
// Shared definitions for the histogram-equalization frame controller.
//
// Contents:
//   - heq_ctrl_state_t : controller state, 2 bits; the encoding is exported on o_mode
//   - Mode* constants  : o_mode values for each state
//   - cnt_width()      : bit width of a counter that indexes 0 .. total-1
package heq_pkg;

  localparam logic [1:0] ModeIdle    = 2'd0;
  localparam logic [1:0] ModeLearn   = 2'd1;
  localparam logic [1:0] ModeWaitLut = 2'd2;
  localparam logic [1:0] ModeStream  = 2'd3;

  typedef enum logic [1:0] {
    StIdle    = ModeIdle,
    StLearn   = ModeLearn,
    StWaitLut = ModeWaitLut,
    StStream  = ModeStream
  } heq_ctrl_state_t;

  // Width that can hold pixel indices 0 .. total-1; never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned total);
    if (total <= 2) return 1;
    return $clog2(total);
  endfunction

endpackage

// File: rtl/heq_frame_counter.sv
// Pixel-in-frame counter for the frame controller.
//
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset
//   start_i      : frame start; the SOF pixel is pixel 0, so the count restarts at 1
//   inc_i        : one more pixel of the current frame was accepted
//   last_o       : the next accepted pixel is the final one (index Total-1)
//   short_o      : fewer than Total-1 pixels accepted so far
module heq_frame_counter
  import heq_pkg::*;
#(
  parameter int unsigned Total = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  input  logic inc_i,
  output logic last_o,
  output logic short_o
);

  localparam int unsigned CntW = cnt_width(Total);
  localparam logic [CntW-1:0] LastIdx = CntW'(Total - 1);

  logic [CntW-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (start_i) begin
      cnt_d = CntW'(1);
    end else if (inc_i) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o  = (cnt_q == LastIdx);
  assign short_o = (cnt_q < LastIdx);

endmodule

// File: rtl/hist_eq_frame_ctrl.sv
// Frame scheduler in front of the histogram-equalization core.
//
// Decides per frame whether the core learns a new LUT (LEARN) or reuses the
// current one (STREAM), forwards pixels through a one-cycle register stage,
// generates the core's end-of-frame strobe, drops pixels while the LUT is being
// built, and flags short frames and LUT-build timeouts on o_err.
//
// Ports:
//   i_clk, i_rst                          : clock, asynchronous active-high reset
//   i_src_valid/i_src_gray/i_src_sof      : source pixel stream
//   o_src_ready                           : source handshake (combinational)
//   i_relearn                             : request a LEARN frame at the next frame start
//   o_core_valid/o_core_gray/o_core_end   : registered pixel stream to the core
//   i_core_ready, i_core_done             : core back-pressure, LUT-build-complete pulse
//   o_mode                                : state (0 idle, 1 learn, 2 wait LUT, 3 stream)
//   o_err                                 : one-cycle pulse on short frame or LUT timeout
//   o_frame_cnt, o_drop_cnt               : status counters, built only when the macro
//                                           HEQ_CTRL_STATUS_EN is defined; tied to 0 otherwise
module hist_eq_frame_ctrl
  import heq_pkg::*;
#(
  parameter int unsigned WIDTH        = 320,
  parameter int unsigned HEIGHT       = 240,
  parameter int unsigned REUSE_FRAMES = 8,
  parameter int unsigned LUT_TIMEOUT  = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_src_valid,
  input  logic [7:0]  i_src_gray,
  input  logic        i_src_sof,
  output logic        o_src_ready,
  input  logic        i_relearn,
  output logic        o_core_valid,
  output logic [7:0]  o_core_gray,
  output logic        o_core_end,
  input  logic        i_core_ready,
  input  logic        i_core_done,
  output logic [1:0]  o_mode,
  output logic        o_err,
  output logic [15:0] o_frame_cnt,
  output logic [15:0] o_drop_cnt
);

  localparam int unsigned TOTAL  = WIDTH * HEIGHT;
  localparam int unsigned WaitW  = $clog2(LUT_TIMEOUT + 1);
  localparam int unsigned ReuseW = $clog2(REUSE_FRAMES + 1);

  heq_ctrl_state_t state_d, state_q;
  logic              lut_ok_d, lut_ok_q;
  logic              relearn_pend_d, relearn_pend_q;
  logic [ReuseW-1:0] reuse_cnt_d, reuse_cnt_q;
  logic [WaitW-1:0]  wait_cnt_d, wait_cnt_q;
  logic              core_valid_d, core_valid_q;
  logic [7:0]        core_gray_d, core_gray_q;
  logic              core_end_d, core_end_q;
  logic              err_d, err_q;

  logic in_frame, abort, src_ready, xfer, need_learn;
  logic cnt_start, cnt_inc, frame_last, frame_short;
  logic frame_end, drop;

  heq_frame_counter #(
    .Total (TOTAL)
  ) u_frame_counter (
    .clk_i   (i_clk),
    .rst_i   (i_rst),
    .start_i (cnt_start),
    .inc_i   (cnt_inc),
    .last_o  (frame_last),
    .short_o (frame_short)
  );

  assign in_frame = (state_q == StLearn) || (state_q == StStream);
  // A new SOF before the final pixel truncates the frame; the SOF itself is refused
  // so the source re-presents it once we are back in idle.
  assign abort = in_frame && i_src_valid && i_src_sof && frame_short;

  always_comb begin
    src_ready = 1'b1;
    if (in_frame) begin
      src_ready = i_core_ready && !abort;
    end
  end

  assign o_src_ready = src_ready;
  assign xfer        = i_src_valid && src_ready;
  assign need_learn  = !lut_ok_q || relearn_pend_q ||
                       (reuse_cnt_q == ReuseW'(REUSE_FRAMES));

  always_comb begin
    state_d        = state_q;
    lut_ok_d       = lut_ok_q;
    relearn_pend_d = relearn_pend_q;
    reuse_cnt_d    = reuse_cnt_q;
    wait_cnt_d     = wait_cnt_q;
    core_valid_d   = 1'b0;
    core_gray_d    = core_gray_q;
    core_end_d     = 1'b0;
    err_d          = 1'b0;
    cnt_start      = 1'b0;
    cnt_inc        = 1'b0;
    frame_end      = 1'b0;
    drop           = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (xfer) begin
          if (i_src_sof) begin
            cnt_start    = 1'b1;
            core_valid_d = 1'b1;
            core_gray_d  = i_src_gray;
            state_d      = need_learn ? StLearn : StStream;
          end else begin
            drop = 1'b1;
          end
        end
      end

      StLearn, StStream: begin
        if (abort) begin
          core_end_d = 1'b1;
          err_d      = 1'b1;
          if (state_q == StLearn) begin
            state_d    = StWaitLut;
            wait_cnt_d = '0;
          end else begin
            state_d = StIdle;
          end
        end else if (xfer) begin
          core_valid_d = 1'b1;
          core_gray_d  = i_src_gray;
          cnt_inc      = 1'b1;
          if (frame_last) begin
            core_end_d = 1'b1;
            frame_end  = 1'b1;
            if (state_q == StLearn) begin
              state_d    = StWaitLut;
              wait_cnt_d = '0;
            end else begin
              state_d = StIdle;
              if (reuse_cnt_q != ReuseW'(REUSE_FRAMES)) begin
                reuse_cnt_d = reuse_cnt_q + ReuseW'(1);
              end
            end
          end
        end
      end

      StWaitLut: begin
        drop = xfer;
        // Done wins over a simultaneous timeout.
        if (i_core_done) begin
          lut_ok_d       = 1'b1;
          reuse_cnt_d    = '0;
          relearn_pend_d = 1'b0;
          state_d        = StIdle;
        end else if (wait_cnt_q == WaitW'(LUT_TIMEOUT - 1)) begin
          err_d    = 1'b1;
          lut_ok_d = 1'b0;
          state_d  = StIdle;
        end else begin
          wait_cnt_d = wait_cnt_q + WaitW'(1);
        end
      end

      default: state_d = StIdle;
    endcase

    // A request arriving alongside core-done still applies to the following frame.
    if (i_relearn) begin
      relearn_pend_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q        <= StIdle;
      lut_ok_q       <= 1'b0;
      relearn_pend_q <= 1'b0;
      reuse_cnt_q    <= '0;
      wait_cnt_q     <= '0;
      core_valid_q   <= 1'b0;
      core_gray_q    <= '0;
      core_end_q     <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      lut_ok_q       <= lut_ok_d;
      relearn_pend_q <= relearn_pend_d;
      reuse_cnt_q    <= reuse_cnt_d;
      wait_cnt_q     <= wait_cnt_d;
      core_valid_q   <= core_valid_d;
      core_gray_q    <= core_gray_d;
      core_end_q     <= core_end_d;
      err_q          <= err_d;
    end
  end

  assign o_core_valid = core_valid_q;
  assign o_core_gray  = core_gray_q;
  assign o_core_end   = core_end_q;
  assign o_err        = err_q;
  assign o_mode       = state_q;

`ifdef HEQ_CTRL_STATUS_EN
  logic [15:0] frame_cnt_d, frame_cnt_q;
  logic [15:0] drop_cnt_d, drop_cnt_q;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    if (frame_end) frame_cnt_d = frame_cnt_q + 16'd1;
    if (drop)      drop_cnt_d  = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign o_frame_cnt = frame_cnt_q;
  assign o_drop_cnt  = drop_cnt_q;
`else
  logic unused_status;
  assign unused_status = frame_end ^ drop;
  assign o_frame_cnt   = '0;
  assign o_drop_cnt    = '0;
`endif

endmodule

// File: tb/tb_hist_eq_frame_ctrl.sv
module tb_hist_eq_frame_ctrl;

  localparam int W     = 4;
  localparam int H     = 2;
  localparam int TOTAL = W * H;
  localparam int REUSE = 2;
  localparam int TMO   = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        src_valid = 1'b0;
  logic [7:0]  src_gray = 8'd0;
  logic        src_sof = 1'b0;
  logic        src_ready;
  logic        relearn = 1'b0;
  logic        core_valid;
  logic [7:0]  core_gray;
  logic        core_end;
  logic        core_ready = 1'b1;
  logic        core_done = 1'b0;
  logic [1:0]  mode;
  logic        err;
  logic [15:0] frame_cnt;
  logic [15:0] drop_cnt;

  always #5 clk = ~clk;

  hist_eq_frame_ctrl #(
    .WIDTH        (W),
    .HEIGHT       (H),
    .REUSE_FRAMES (REUSE),
    .LUT_TIMEOUT  (TMO)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_src_valid  (src_valid),
    .i_src_gray   (src_gray),
    .i_src_sof    (src_sof),
    .o_src_ready  (src_ready),
    .i_relearn    (relearn),
    .o_core_valid (core_valid),
    .o_core_gray  (core_gray),
    .o_core_end   (core_end),
    .i_core_ready (core_ready),
    .i_core_done  (core_done),
    .o_mode       (mode),
    .o_err        (err),
    .o_frame_cnt  (frame_cnt),
    .o_drop_cnt   (drop_cnt)
  );

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model: frame phase, pixels taken so far, LUT validity and reuse budget.
  int          m_mode;  // 0 idle, 1 learn, 2 wait LUT, 3 stream
  int          m_pix;
  bit          m_lut_ok;
  bit          m_pend;
  int          m_reuse;
  int          m_wait;
  logic [15:0] m_frames;
  logic [15:0] m_drops;
  bit          m_xfer;
  bit          e_valid, e_end, e_err;
  logic [7:0]  e_gray;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] st_exp(input logic [15:0] v);
`ifdef HEQ_CTRL_STATUS_EN
    return v;
`else
    return 16'd0 & v;
`endif
  endfunction

  task automatic model_reset();
    m_mode = 0; m_pix = 0; m_lut_ok = 0; m_pend = 0; m_reuse = 0; m_wait = 0;
    m_frames = 0; m_drops = 0; m_xfer = 0;
    e_valid = 0; e_end = 0; e_err = 0; e_gray = 0;
  endtask

  // One clock cycle: check registered outputs, apply inputs, check ready, advance model.
  task automatic step(input bit v, input bit s, input logic [7:0] g, input bit rl,
                      input bit cr, input bit cd);
    bit abort;
    bit rdy;
    bit learn;
    @(negedge clk);
    check("core_valid", core_valid, e_valid);
    if (e_valid) check("core_gray", core_gray, e_gray);
    check("core_end", core_end, e_end);
    check("err", err, e_err);
    check("mode", mode, m_mode[1:0]);
    check("frame_cnt", frame_cnt, st_exp(m_frames));
    check("drop_cnt", drop_cnt, st_exp(m_drops));
    src_valid = v; src_sof = s; src_gray = g; relearn = rl; core_ready = cr; core_done = cd;
    #1;
    abort = (m_mode == 1 || m_mode == 3) && v && s && (m_pix < TOTAL - 1);
    rdy = (m_mode == 0 || m_mode == 2) ? 1'b1 : (cr && !abort);
    check("src_ready", src_ready, rdy);
    m_xfer = v && rdy;
    e_valid = 0; e_end = 0; e_err = 0;
    case (m_mode)
      0: begin
        if (m_xfer && s) begin
          learn = !m_lut_ok || m_pend || (m_reuse == REUSE);
          m_mode = learn ? 1 : 3;
          m_pix = 1; e_valid = 1; e_gray = g;
        end else if (m_xfer) begin
          m_drops++;
        end
      end
      1, 3: begin
        if (abort) begin
          e_end = 1; e_err = 1;
          if (m_mode == 1) begin m_mode = 2; m_wait = 0; end
          else m_mode = 0;
        end else if (m_xfer) begin
          e_valid = 1; e_gray = g;
          if (m_pix == TOTAL - 1) begin
            e_end = 1; m_frames++;
            if (m_mode == 1) begin m_mode = 2; m_wait = 0; end
            else begin m_mode = 0; if (m_reuse < REUSE) m_reuse++; end
          end else begin
            m_pix++;
          end
        end
      end
      default: begin
        if (m_xfer) m_drops++;
        if (cd) begin
          m_lut_ok = 1; m_reuse = 0; m_pend = 0; m_mode = 0;
        end else if (m_wait == TMO - 1) begin
          e_err = 1; m_lut_ok = 0; m_mode = 0;
        end else begin
          m_wait++;
        end
      end
    endcase
    if (rl) m_pend = 1;
    @(posedge clk);
  endtask

  task automatic idle(input int n, input int done_at);
    for (int i = 0; i < n; i++) step(0, 0, 8'd0, 0, 1, i == done_at);
  endtask

  // Send n pixels (SOF on the first); relearn pulses when pixel rl_idx is first offered.
  task automatic send_frame(input int n, input bit rnd, input int rl_idx, input int exp_mode);
    int tries;
    bit v, cr;
    for (int k = 0; k < n; k++) begin
      tries = 0;
      do begin
        cr = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        v  = rnd ? ($urandom_range(0, 4) != 0) : 1'b1;
        step(v, k == 0, 8'($urandom), (k == rl_idx) && (tries == 0), cr, 0);
        tries++;
      end while (!m_xfer && tries < 60);
      n_checks++;
      assert (m_xfer)
      else begin
        n_fails++;
        $error("FAIL accept_bound: pixel %0d not accepted after %0d cycles, required <60",
               k, tries);
      end
      if (k == 0 && exp_mode >= 0) begin
        #1 check("frame_mode", mode, 16'(exp_mode));
      end
    end
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_valid", core_valid, 0);
    check("rst_gray", core_gray, 0);
    check("rst_end", core_end, 0);
    check("rst_err", err, 0);
    check("rst_mode", mode, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    rst = 1'b0;
    @(posedge clk);

    // First frame learns, then waits for the LUT.
    send_frame(TOTAL, 0, -1, 1);
    #1 check("after_learn_mode", mode, 2);
    // Three pixels dropped while the LUT builds, done five cycles in.
    for (int i = 0; i < 3; i++) step(1, 0, 8'($urandom), 0, 1, 0);
    idle(2, 1);
    #1 check("lut_done_mode", mode, 0);
    check("drops_after_wait", drop_cnt, st_exp(16'd3));

    // Reuse budget of two, then forced relearn.
    send_frame(TOTAL, 1, -1, 3);
    send_frame(TOTAL, 1, -1, 3);
    send_frame(TOTAL, 1, -1, 1);
    #1 check("frames_after_4", frame_cnt, st_exp(16'd4));
    idle(3, 2);

    // Short frame: SOF at pixel 5 of a STREAM frame.
    send_frame(5, 0, -1, 3);
    step(1, 1, 8'h5a, 0, 1, 0);
    #1 check("abort_end", core_end, 1);
    check("abort_valid", core_valid, 0);
    check("abort_err", err, 1);
    check("abort_mode", mode, 0);
    // Reuse count untouched by the abort: two STREAM frames remain.
    send_frame(TOTAL, 0, -1, 3);
    send_frame(TOTAL, 0, -1, 3);
    send_frame(TOTAL, 0, -1, 1);

    // No core-done: timeout error sixteen cycles after entering the wait.
    idle(15, -1);
    #1 check("tmo_not_yet", err, 0);
    idle(1, -1);
    #1 check("tmo_err", err, 1);
    check("tmo_mode", mode, 0);
    send_frame(TOTAL, 1, -1, 1);
    idle(4, 3);

    // Relearn request mid-frame does not disturb the current STREAM frame.
    send_frame(TOTAL, 0, 3, 3);
    #1 check("relearn_frame_done", mode, 0);
    send_frame(TOTAL, 0, -1, 1);
    idle(2, 0);

    // Reset in the middle of a STREAM frame; the following frame must learn.
    send_frame(3, 0, -1, 3);
    @(negedge clk);
    rst = 1'b1;
    src_valid = 0; src_sof = 0; relearn = 0; core_done = 0; core_ready = 1;
    model_reset();
    #1 check("midrst_mode", mode, 0);
    check("midrst_valid", core_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    send_frame(TOTAL, 0, -1, 1);
    idle(2, 1);

    // Randomized traffic checked cycle by cycle against the model.
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0, 8'($urandom),
           $urandom_range(0, 31) == 0, $urandom_range(0, 4) != 0,
           $urandom_range(0, 19) == 0);
    end
    idle(1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
